// File: rtl/msf_pkg.sv
// MSF 60 kHz time-code encoder: shared constants, frame type and keying helper.
// Optional feature macro: MSF_ENC_DUT1_EN (DUT1 code on B1-B16).
package msf_pkg;

  localparam int TICKS_PER_SEC    = 10;
  localparam int SECS_PER_FRAME   = 60;
  localparam int MARKER_OFF_TICKS = 5;

  // Second carrying the LSB of each MSB-first BCD field (bit A)
  localparam int YEAR_LSB_SEC   = 24;
  localparam int MONTH_LSB_SEC  = 29;
  localparam int DOM_LSB_SEC    = 35;
  localparam int DOW_LSB_SEC    = 38;
  localparam int HOUR_LSB_SEC   = 44;
  localparam int MINUTE_LSB_SEC = 51;

  // Fixed 01111110 identifier in A52-A59: ones occupy 53..58
  localparam int FIXED_ONES_FIRST = 53;
  localparam int FIXED_ONES_LAST  = 58;

  // Bit B flag and parity positions
  localparam int BST_WARN_SEC = 53;
  localparam int PAR_YEAR_SEC = 54;
  localparam int PAR_DATE_SEC = 55;
  localparam int PAR_DOW_SEC  = 56;
  localparam int PAR_TIME_SEC = 57;
  localparam int BST_SEC      = 58;

  typedef struct packed {
    logic [7:0] year;
    logic [4:0] month;
    logic [5:0] dom;
    logic [2:0] dow;
    logic [5:0] hour;
    logic [6:0] minute;
    logic       bst;
    logic       bst_warn;
    logic [4:0] dut1;
  } msf_frame_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } msf_state_e;

  // Carrier level for a given position: 1 = on, 0 = off
  function automatic logic carrier_level(input logic [5:0] sec, input logic [3:0] ds,
                                         input logic bit_a, input logic bit_b);
    logic lvl;
    if (sec == 6'd0) begin
      lvl = (ds >= 4'(MARKER_OFF_TICKS));
    end else begin
      case (ds)
        4'd0:    lvl = 1'b0;
        4'd1:    lvl = ~bit_a;
        4'd2:    lvl = ~bit_b;
        default: lvl = 1'b1;
      endcase
    end
    return lvl;
  endfunction

endpackage

// File: rtl/msf_encoder_bit_lookup.sv
// Combinational (frame, second) -> {bit A, bit B} lookup for the MSF code,
// including odd-parity bits. DUT1 bits B1-B16 only when MSF_ENC_DUT1_EN is defined.
module msf_bit_lookup
  import msf_pkg::*;
(
  input  msf_frame_t i_frame,
  input  logic [5:0] i_sec,
  output logic       o_bit_a,
  output logic       o_bit_b
);

  logic [63:0] w_a_vec;
  logic [63:0] w_b_vec;
  logic [63:0] w_dut1_vec;

`ifdef MSF_ENC_DUT1_EN
  localparam int DUT1_MAX       = 8;
  localparam int DUT1_NEG_FIRST = 9;

  logic [3:0] w_dut1_mag;

  // DUT1: positive sets B1..Bm, negative sets B9..B(8+m), m clamped to 8
  always_comb begin
    w_dut1_vec = '0;
    w_dut1_mag = (i_frame.dut1[3:0] > 4'(DUT1_MAX)) ? 4'(DUT1_MAX) : i_frame.dut1[3:0];
    for (int i = 1; i <= DUT1_MAX; i++) begin
      if (4'(i) <= w_dut1_mag) begin
        if (i_frame.dut1[4]) w_dut1_vec[DUT1_NEG_FIRST + i - 1] = 1'b1;
        else                 w_dut1_vec[i] = 1'b1;
      end
    end
  end
`else
  logic w_unused_dut1;
  assign w_unused_dut1 = ^i_frame.dut1;
  assign w_dut1_vec    = '0;
`endif

  // Build the full per-second A/B bit maps; fields go out MSB first
  always_comb begin
    w_a_vec = '0;
    w_b_vec = w_dut1_vec;
    for (int i = 0; i < 8; i++) w_a_vec[YEAR_LSB_SEC - i]   = i_frame.year[i];
    for (int i = 0; i < 5; i++) w_a_vec[MONTH_LSB_SEC - i]  = i_frame.month[i];
    for (int i = 0; i < 6; i++) w_a_vec[DOM_LSB_SEC - i]    = i_frame.dom[i];
    for (int i = 0; i < 3; i++) w_a_vec[DOW_LSB_SEC - i]    = i_frame.dow[i];
    for (int i = 0; i < 6; i++) w_a_vec[HOUR_LSB_SEC - i]   = i_frame.hour[i];
    for (int i = 0; i < 7; i++) w_a_vec[MINUTE_LSB_SEC - i] = i_frame.minute[i];
    for (int s = FIXED_ONES_FIRST; s <= FIXED_ONES_LAST; s++) w_a_vec[s] = 1'b1;
    w_b_vec[BST_WARN_SEC] = i_frame.bst_warn;
    w_b_vec[PAR_YEAR_SEC] = ~^i_frame.year;
    w_b_vec[PAR_DATE_SEC] = ~^{i_frame.month, i_frame.dom};
    w_b_vec[PAR_DOW_SEC]  = ~^i_frame.dow;
    w_b_vec[PAR_TIME_SEC] = ~^{i_frame.hour, i_frame.minute};
    w_b_vec[BST_SEC]      = i_frame.bst;
  end

  assign o_bit_a = w_a_vec[i_sec];
  assign o_bit_b = w_b_vec[i_sec];

endmodule

// File: rtl/msf_encoder.sv
// MSF 60 kHz carrier keying generator paced by a 100 ms tick.
// Optional feature macro: MSF_ENC_DUT1_EN (latch dut1_i and send DUT1 on B1-B16).
//
// state   | meaning
// ST_IDLE | carrier on, counters held at 0, waiting for a tick with run_i=1
// ST_RUN  | transmitting; each tick advances ds/sec, frame regs latched at sec0/ds0
module msf_encoder
  import msf_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_i,
  input  logic       run_i,
  input  logic [7:0] year_i,
  input  logic [4:0] month_i,
  input  logic [5:0] dom_i,
  input  logic [2:0] dow_i,
  input  logic [5:0] hour_i,
  input  logic [6:0] minute_i,
  input  logic       bst_i,
  input  logic       bst_warn_i,
  input  logic [4:0] dut1_i,
  output logic       carrier_o,
  output logic [5:0] second_o,
  output logic       frame_start_o
);

  msf_state_e r_state;
  msf_state_e w_state_nxt;
  logic [5:0] r_sec;
  logic [3:0] r_ds;
  msf_frame_t r_frame;
  logic       r_carrier;
  logic       r_frame_start;

  logic [5:0] w_sec_nxt;
  logic [3:0] w_ds_nxt;
  logic       w_advance;
  logic       w_enter;
  logic       w_frame_start;
  logic       w_bit_a;
  logic       w_bit_b;
  msf_frame_t w_frame_in;

  // Snapshot of the inputs taken at the start of every frame
  always_comb begin
    w_frame_in          = '0;
    w_frame_in.year     = year_i;
    w_frame_in.month    = month_i;
    w_frame_in.dom      = dom_i;
    w_frame_in.dow      = dow_i;
    w_frame_in.hour     = hour_i;
    w_frame_in.minute   = minute_i;
    w_frame_in.bst      = bst_i;
    w_frame_in.bst_warn = bst_warn_i;
`ifdef MSF_ENC_DUT1_EN
    w_frame_in.dut1     = dut1_i;
`endif
  end

`ifndef MSF_ENC_DUT1_EN
  logic w_unused_dut1_in;
  assign w_unused_dut1_in = ^dut1_i;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state and next position; dropping run_i always wins over a tick
  always_comb begin
    w_state_nxt = r_state;
    w_advance   = 1'b0;
    w_enter     = 1'b0;
    w_sec_nxt   = r_sec;
    w_ds_nxt    = r_ds;
    case (r_state)
      ST_IDLE: begin
        if (run_i && tick_i) begin
          w_state_nxt = ST_RUN;
          w_enter     = 1'b1;
        end
      end
      ST_RUN: begin
        if (!run_i)      w_state_nxt = ST_IDLE;
        else if (tick_i) w_advance   = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_advance) begin
      if (r_ds == 4'(TICKS_PER_SEC - 1)) begin
        w_ds_nxt  = 4'd0;
        w_sec_nxt = (r_sec == 6'(SECS_PER_FRAME - 1)) ? 6'd0 : r_sec + 6'd1;
      end else begin
        w_ds_nxt = r_ds + 4'd1;
      end
    end
    if (w_enter || w_state_nxt == ST_IDLE) begin
      w_sec_nxt = 6'd0;
      w_ds_nxt  = 4'd0;
    end
  end

  assign w_frame_start = w_enter || (w_advance && w_sec_nxt == 6'd0 && w_ds_nxt == 4'd0);

  // Bits are looked up for the position being entered, from the latched frame
  msf_bit_lookup u_lookup (
    .i_frame (r_frame),
    .i_sec   (w_sec_nxt),
    .o_bit_a (w_bit_a),
    .o_bit_b (w_bit_b)
  );

  // Position counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sec <= 6'd0;
      r_ds  <= 4'd0;
    end else begin
      r_sec <= w_sec_nxt;
      r_ds  <= w_ds_nxt;
    end
  end

  // Frame latch: inputs are only sampled as a new frame begins
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)            r_frame <= '0;
    else if (w_frame_start) r_frame <= w_frame_in;
  end

  // Registered carrier and frame-start pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_carrier     <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_frame_start;
      if (w_state_nxt == ST_IDLE)     r_carrier <= 1'b1;
      else if (w_advance || w_enter)  r_carrier <= carrier_level(w_sec_nxt, w_ds_nxt, w_bit_a, w_bit_b);
    end
  end

  assign carrier_o     = r_carrier;
  assign second_o      = r_sec;
  assign frame_start_o = r_frame_start;

endmodule

// File: tb/tb_msf_encoder.sv
// Scoreboard bench for msf_encoder: each tick pushes the expected
// {carrier, second, frame_start}; a monitor pops and compares after the edge.
// Honours MSF_ENC_DUT1_EN for the DUT1 expectations.
module tb_msf_encoder;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       tick_i;
  logic       run_i;
  logic [7:0] year_i;
  logic [4:0] month_i;
  logic [5:0] dom_i;
  logic [2:0] dow_i;
  logic [5:0] hour_i;
  logic [6:0] minute_i;
  logic       bst_i;
  logic       bst_warn_i;
  logic [4:0] dut1_i;
  logic       carrier_o;
  logic [5:0] second_o;
  logic       frame_start_o;

  msf_encoder dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .tick_i        (tick_i),
    .run_i         (run_i),
    .year_i        (year_i),
    .month_i       (month_i),
    .dom_i         (dom_i),
    .dow_i         (dow_i),
    .hour_i        (hour_i),
    .minute_i      (minute_i),
    .bst_i         (bst_i),
    .bst_warn_i    (bst_warn_i),
    .dut1_i        (dut1_i),
    .carrier_o     (carrier_o),
    .second_o      (second_o),
    .frame_start_o (frame_start_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic       carrier;
    logic [5:0] sec;
    logic       fs;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [59:0] fa[2];
  logic [59:0] fb[2];

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic void set_a(input int f, input int start, input string s);
    for (int k = 0; k < s.len(); k++) fa[f][start + k] = (s[k] == "1");
  endfunction

  function automatic logic exp_carrier(input int sec, input int ds, input logic a, input logic b);
    if (sec == 0) return (ds >= 5);
    if (ds == 0)  return 1'b0;
    if (ds == 1)  return ~a;
    if (ds == 2)  return ~b;
    return 1'b1;
  endfunction

  task automatic set_frame(input int f);
    if (f == 0) begin
      year_i = 8'h23; month_i = 5'h06; dom_i = 6'h15; dow_i = 3'd4;
      hour_i = 6'h14; minute_i = 7'h37; bst_i = 1'b1; bst_warn_i = 1'b0; dut1_i = 5'b1_0011;
    end else begin
      year_i = 8'h99; month_i = 5'h12; dom_i = 6'h31; dow_i = 3'd6;
      hour_i = 6'h23; minute_i = 7'h59; bst_i = 1'b0; bst_warn_i = 1'b1; dut1_i = 5'b0_1111;
    end
  endtask

  // Called at a falling edge; one tick, then one quiet cycle
  task automatic tick_exp(input logic c, input int sec, input logic fs);
    exp_t e;
    e.carrier = c;
    e.sec     = 6'(sec);
    e.fs      = fs;
    exp_q.push_back(e);
    tick_i = 1'b1;
    @(negedge clk_i);
    tick_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic run_ticks(input int f, input int k0, input int n);
    for (int k = k0; k < k0 + n; k++) begin
      int sec;
      int ds;
      sec = k / 10;
      ds  = k % 10;
      tick_exp(exp_carrier(sec, ds, fa[f][sec], fb[f][sec]), sec, (k == 0));
    end
  endtask

  // Monitor: every sampled tick must produce the next queued response
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      if (tick_i === 1'b1) begin
        @(negedge clk_i);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tick_response: got unexpected response, no expectation queued");
        end else begin
          e = exp_q.pop_front();
          check("tick_response", {carrier_o, second_o, frame_start_o}, {e.carrier, e.sec, e.fs});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // Hand-decoded MSF tables. Frame 0: 2023-06-15 dow4 14:37 BST; frame 1: 1999-12-31 dow6 23:59 warn
    fa[0] = '0; fb[0] = '0; fa[1] = '0; fb[1] = '0;
    set_a(0, 17, "00100011"); set_a(0, 25, "00110"); set_a(0, 30, "010101");
    set_a(0, 36, "100");      set_a(0, 39, "010100"); set_a(0, 45, "0110111");
    set_a(0, 52, "01111110");
    set_a(1, 17, "10011001"); set_a(1, 25, "10010"); set_a(1, 30, "110001");
    set_a(1, 36, "110");      set_a(1, 39, "100011"); set_a(1, 45, "1011001");
    set_a(1, 52, "01111110");
    fb[0][58] = 1'b1;
    fb[1][53] = 1'b1; fb[1][54] = 1'b1; fb[1][56] = 1'b1;
`ifdef MSF_ENC_DUT1_EN
    fb[0][11:9] = 3'b111;
    fb[1][8:1]  = 8'hFF;
`endif

    rst_ni = 1'b0; tick_i = 1'b0; run_i = 1'b0;
    set_frame(0);
    repeat (2) @(negedge clk_i);
    check("reset_carrier", {7'd0, carrier_o}, 8'd1);
    check("reset_second", {2'd0, second_o}, 8'd0);
    check("reset_frame_start", {7'd0, frame_start_o}, 8'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    tick_exp(1'b1, 0, 1'b0);              // tick while idle: no effect
    run_i = 1'b1;
    @(negedge clk_i);
    check("run_no_tick_carrier", {7'd0, carrier_o}, 8'd1);

    run_ticks(0, 0, 201);                 // frame 0 up to sec 20 ds 0
    set_frame(1);                         // mid-frame change must not show
    run_ticks(0, 201, 399);
    run_ticks(1, 0, 600);                 // frame 1 latched at wrap
    run_ticks(1, 0, 105);                 // next frame to sec 10 ds 4

    run_i = 1'b0;
    @(negedge clk_i);
    check("drop_run_carrier", {7'd0, carrier_o}, 8'd1);
    check("drop_run_second", {2'd0, second_o}, 8'd0);
    tick_exp(1'b1, 0, 1'b0);

    run_i = 1'b1;
    run_ticks(1, 0, 3);
    run_i = 1'b0;
    tick_exp(1'b1, 0, 1'b0);              // tick and run fall together: idle
    run_i = 1'b1;
    run_ticks(1, 0, 301);                 // to sec 30 ds 0

    rst_ni = 1'b0;
    #1;
    check("async_reset_carrier", {7'd0, carrier_o}, 8'd1);
    check("async_reset_second", {2'd0, second_o}, 8'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    run_ticks(1, 0, 12);

    repeat (4) @(negedge clk_i);
    check("queue_drained", 8'(exp_q.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
